readout_sequencer: RTL
======================

Name: readout_sequencer

Overview:
- Sequences a parallel-load / serial-unload word buffer for pixel readout.
- Accepts one frame of LENGTH words in parallel over a valid/ready handshake.
- Streams the frame out one word per handshake, word 0 first, with a last flag.
- Maintains a wrapping frame counter.
- Sits between the ADC/pixel-array capture logic and the downstream serial output stage.
- Replaces asynchronous set/shift pulsing with fully synchronous control on one clock.

Parameters:
- LENGTH, 4: words per frame; must be ≥ 2.
- BITS, 4: width of one word.
- FRAME_W, 8: width of frame_count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; state clears while reset = 0.
- in_valid  input  1  parallel frame present on in_data.
- in_ready  output  1  sequencer can accept a frame this cycle.
- in_data  input  LENGTH*BITS  frame; word i = in_data[i*BITS +: BITS].
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  BITS  current word.
- out_last  output  1  current word is word LENGTH-1.
- abort  input  1  synchronous flush of the current frame.
- busy  output  1  frame held (state SHIFT).
- frame_count  output  FRAME_W  count of fully delivered frames; wraps.

Behaviour:
- States: IDLE, SHIFT. Word index idx has width $clog2(LENGTH).
- Reset (reset = 0, asynchronous):
  - state = IDLE, idx = 0, buffer = all 0, frame_count = 0.
  - Outputs during reset: out_valid = 0, out_last = 0, out_data = 0, busy = 0, in_ready = 1.
- in_ready = (state == IDLE) && !abort; combinational.
- Accept: in_valid && in_ready at edge N.
  - Buffer loads in_data; idx = 0; state becomes SHIFT.
  - out_valid = 1 and out_data = word 0 after edge N (1-cycle latency).
- In SHIFT:
  - out_valid = 1; out_data = buffer word 0 (head); out_last = (idx == LENGTH-1).
  - Transfer: out_valid && out_ready && !abort at an edge.
    - The buffer shifts down one word; the top word fills with 0.
    - idx increments.
  - If the transfer carries out_last, the same edge also sets state = IDLE, idx = 0 and frame_count += 1, modulo 2^FRAME_W.
- Back-pressure: while out_ready = 0, out_data, out_last and idx hold. No word is dropped or duplicated.
- Throughput: back-to-back transfers give one word per cycle. After the last word there is one IDLE cycle, so the next frame's first word appears at earliest 2 cycles after the last transfer. Sustained rate is LENGTH words per LENGTH+1 cycles.
- in_valid while in SHIFT is ignored; in_ready = 0, and the upstream holds its data.
- abort at an edge in SHIFT:
  - state = IDLE, idx = 0, buffer cleared to 0; frame_count unchanged.
  - A simultaneous out_ready does not count as a transfer.
- abort in IDLE: no accept that cycle, even with in_valid = 1 (in_ready is forced 0); no other effect.
- Reset asserted mid-frame: the frame is discarded and all outputs return to reset values immediately.
- frame_count wraps from 2^FRAME_W−1 to 0 with no flag.
- No X is ever driven on out_data.

Decomposition:
- Shared package readout_pkg:
  - typedef enum logic {IDLE, SHIFT} readout_state_t
  - default constants READOUT_LENGTH = 4, READOUT_BITS = 4.
- Sub-module readout_shift_buffer (clk, reset, load, shift, clear, in_data, head):
  - LENGTH×BITS synchronous storage with parallel load and shift-toward-word-0 with zero fill.
  - Priority: clear > load > shift.
- The sequencer holds the FSM, idx, handshake logic and frame_count.

Test Plan:
- Reset then idle (LENGTH=4, BITS=4): hold reset = 0 for 3 cycles, release → in_ready = 1, out_valid = 0, out_data = 0, frame_count = 0.
- Single frame, out_ready = 1: in_data = 16'hDCBA accepted at edge N → out_data = A, B, C, D on cycles N+1..N+4; out_last only with D; frame_count = 1; in_ready = 1 from N+5.
- Back-pressure: accept 16'h4321, hold out_ready = 0 for 3 cycles with out_data stable at 1 → then out_ready = 1 gives 2, 3, 4 with no loss; in_valid held high during SHIFT is not accepted.
- Abort mid-frame: abort after word 2 has transferred, with out_ready = 1 that cycle → state IDLE, out_valid = 0 next cycle, frame_count unchanged; the next frame 16'h8765 streams 5, 6, 7, 8 cleanly.
- Asynchronous reset mid-frame: drop reset between clock edges during SHIFT → out_valid, out_last and busy go 0 immediately; after release, a new frame streams correctly.
- Wrap: FRAME_W = 2, stream 5 frames back-to-back → frame_count 1, 2, 3, 0, 1; each frame has 1 idle cycle after its out_last transfer.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and default sizing for the pixel readout sequencer.
package readout_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } readout_state_t;

    localparam int READOUT_LENGTH = 4;
    localparam int READOUT_BITS   = 4;

endpackage

// File: rtl/readout_shift_buffer.sv
// Parallel-load word buffer that unloads toward word 0, zero-filling the top.
module readout_shift_buffer
    import readout_pkg::*;
#(
    parameter int LENGTH = READOUT_LENGTH,
    parameter int BITS   = READOUT_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   shift,
    input  logic                   clear,
    input  logic [LENGTH*BITS-1:0] in_data,
    output logic [BITS-1:0]        head
);

    logic [LENGTH-1:0][BITS-1:0] mem_q;

    // Storage update; a flush wins over a new load, a load wins over a shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
        end else if (clear) begin
            mem_q <= '0;
        end else if (load) begin
            mem_q <= in_data;
        end else if (shift) begin
            mem_q <= {{BITS{1'b0}}, mem_q[LENGTH-1:1]};
        end
    end

    assign head = mem_q[0];

endmodule

// File: rtl/readout_sequencer.sv
// Frame sequencer: accepts a whole frame in parallel, streams it out word 0 first.
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int LENGTH  = READOUT_LENGTH,
    parameter int BITS    = READOUT_BITS,
    parameter int FRAME_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LENGTH*BITS-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BITS-1:0]        out_data,
    output logic                   out_last,
    input  logic                   abort,
    output logic                   busy,
    output logic [FRAME_W-1:0]     frame_count
);

    localparam int IDX_W = $clog2(LENGTH);

    readout_state_t     state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] fc_q, fc_d;
    logic               load, shift, clear;
    logic               at_last;
    logic [BITS-1:0]    head;

    assign at_last = (idx_q == IDX_W'(LENGTH - 1));

    // State, word index and delivered-frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fc_q    <= fc_d;
        end
    end

    // Next state and buffer control; abort overrides any concurrent transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fc_d    = fc_q;
        load    = 1'b0;
        shift   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    clear   = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (out_ready) begin
                    shift = 1'b1;
                    if (at_last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        fc_d    = fc_q + FRAME_W'(1);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    readout_shift_buffer #(
        .LENGTH (LENGTH),
        .BITS   (BITS)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .clear   (clear),
        .in_data (in_data),
        .head    (head)
    );

    assign in_ready    = (state_q == IDLE) && !abort;
    assign out_valid   = (state_q == SHIFT);
    assign busy        = (state_q == SHIFT);
    assign out_last    = (state_q == SHIFT) && at_last;
    assign out_data    = (state_q == SHIFT) ? head : '0;
    assign frame_count = fc_q;

endmodule
